// File: rtl/seven_seg_scan_if.sv
// seven_seg_scan_if: value/mask inputs and segment/digit outputs of the scanned display driver
//   i_digits_in   hex nibbles, digit k in bits [4k+3:4k]
//   i_load        capture i_digits_in into the shadow register
//   i_blank_mask  1 = digit k shows no segments
//   o_seg_out     {g,f,e,d,c,b,a}, active-low
//   o_digit_en    active-low digit enables, at most one low
//   o_frame_start one-cycle pulse in the first cycle of every frame
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 2
);
  logic [4*NUM_DIGITS-1:0] i_digits_in;
  logic                    i_load;
  logic [NUM_DIGITS-1:0]   i_blank_mask;
  logic [6:0]              o_seg_out;
  logic [NUM_DIGITS-1:0]   o_digit_en;
  logic                    o_frame_start;
  modport master (output i_digits_in, i_load, i_blank_mask, input o_seg_out, o_digit_en, o_frame_start);
  modport slave  (input i_digits_in, i_load, i_blank_mask, output o_seg_out, o_digit_en, o_frame_start);
endinterface

// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed common-anode seven-segment driver with dead-time and frame-synchronous update
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    seven_seg_scan_if slave: digit values, load, blank mask in; segments, digit enables, frame pulse out
module seven_seg_scan #(
  parameter int NUM_DIGITS   = 2,
  parameter int SLOT_CYCLES  = 24000,
  parameter int BLANK_CYCLES = 240
) (
  input logic             clk,
  input logic             reset,
  seven_seg_scan_if.slave bus
);
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] C_BEND = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t                  r_state, w_state_nxt;
  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*NUM_DIGITS-1:0] r_shadow, r_active;
  logic [6:0]              r_seg, w_seg;
  logic [NUM_DIGITS-1:0]   r_en, w_en;
  logic                    r_fs;
  logic                    w_slot_end, w_frame, w_drive;
  logic [3:0]              w_nib;
  // r_cnt/r_idx/r_state describe the output cycle being registered on this edge,
  // so the registered outputs line up exactly with the slot position.
  assign w_slot_end = (r_cnt == C_LAST);
  assign w_frame    = (r_cnt == '0) && (r_idx == '0);
  assign w_drive    = (r_state == DRIVE);
  assign w_nib      = r_active[{r_idx, 2'b00} +: 4];
  always_comb begin
    w_state_nxt = r_state;
    w_seg       = 7'h7F;
    w_en        = '1;
    w_state_nxt = w_slot_end ? BLANK : ((r_cnt == C_BEND) ? DRIVE : r_state);
    w_seg       = (w_drive && !bus.i_blank_mask[r_idx]) ? SEG[w_nib] : 7'h7F;
    w_en        = w_drive ? ~(NUM_DIGITS'(1) << r_idx) : '1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= BLANK;
    else        r_state <= w_state_nxt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_seg    <= 7'h7F;
      r_en     <= '1;
      r_fs     <= 1'b0;
    end else begin
      r_cnt    <= w_slot_end ? '0 : r_cnt + 1'b1;
      r_idx    <= w_slot_end ? ((r_idx == I_LAST) ? '0 : r_idx + 1'b1) : r_idx;
      r_shadow <= bus.i_load ? bus.i_digits_in : r_shadow;
      // Swap in new values on the edge that opens a frame; a load on that same
      // edge (last cycle of the previous frame) bypasses the shadow.
      r_active <= w_frame ? (bus.i_load ? bus.i_digits_in : r_shadow) : r_active;
      r_seg    <= w_seg;
      r_en     <= w_en;
      r_fs     <= w_frame;
    end
  end
  assign bus.o_seg_out     = r_seg;
  assign bus.o_digit_en    = r_en;
  assign bus.o_frame_start = r_fs;
endmodule
